sc_bitstream_decoder: RTL
=========================

# sc_bitstream_decoder

Stochastic-to-binary decoder: counts ones on a unipolar stochastic bitstream over a fixed window of 2^WIDTH valid samples and presents the count as a binary word with a valid/ready handshake. Sits at the output end of stochastic datapaths such as the n-input adder chain, converting the scaled-sum stream back into the binary domain for readout or further binary processing.

## Interface
- WIDTH, 8, log2 of window length; window = 2^WIDTH valid samples; legal range 1..16.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately; deassertion synchronous to clk.
- start  input  1  begin a conversion; sampled only in IDLE, or in HOLD on the same cycle as an output handshake.
- clear  input  1  synchronous abort; returns to IDLE from any state, discarding partial count and any held result.
- bit_valid  input  1  bit_in carries a sample this cycle.
- bit_in  input  1  stochastic bitstream sample.
- busy  output  1  high in ACCUM.
- out_valid  output  1  result available (high exactly in HOLD).
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+1  decoded value; format per Configuration.

## Operation
- States: IDLE, ACCUM, HOLD. Reset state IDLE.
- IDLE: start=1 -> ACCUM; ones counter and sample counter cleared.
- ACCUM: each cycle with bit_valid=1 increments sample counter; also increments ones counter when bit_in=1. Cycles with bit_valid=0 change nothing. Start ignored.
- When the 2^WIDTH-th valid sample is captured, result is registered from the final ones count (including that sample) and state -> HOLD.
- HOLD: result and out_valid stable until out_valid && out_ready. On handshake: start=1 -> ACCUM (counters cleared, back-to-back conversion); else -> IDLE. Samples during HOLD discarded.
- clear=1 has priority over start, handshake and sample capture; next state IDLE, out_valid low next cycle, result cleared to 0.
- Ones counter is WIDTH+1 bits; maximum 2^WIDTH (all ones) fits without wrap. Sample counter WIDTH+1 bits or equivalent terminal detect; no wrap within a window.
- Unipolar result = ones count, range 0..2^WIDTH, unsigned.

## Timing
- Reset values: busy=0, out_valid=0, result=0; internal counters 0.
- start in IDLE at edge t -> busy=1 from t+1; first sample eligible at edge t+1.
- With continuous bit_valid, last sample captured at edge t+2^WIDTH; out_valid=1 and result valid after that edge (busy=0 same cycle).
- Handshake at edge h -> out_valid=0 after h (or busy=1 if restarted).
- Result register updates only on entering HOLD or on clear/reset; never while out_valid=1.
- rst asserted mid-ACCUM or mid-HOLD: immediate return to reset values; no result emitted.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- SC_DECODER_BIPOLAR_EN defined: result is two's-complement signed, bipolar decoding, result = 2*ones - 2^WIDTH, range -2^WIDTH..+2^WIDTH in WIDTH+1... bits (WIDTH+2 bits; result width becomes WIDTH+2 under this macro).
- Not defined: unipolar unsigned ones count, width WIDTH+1.
- Control, handshake and timing identical in both builds.

## Test plan
- WIDTH=4, start, 16 cycles bit_valid=1, bit_in=1 -> out_valid after edge 16, result=16 (bipolar: +16).
- WIDTH=4, bit_in alternating 1/0 with bit_valid=1 every other cycle -> conversion takes 32 cycles, result=8 only if sampled bits alternate; with all sampled bits 0 -> result=0 (bipolar: -16).
- Hold out_ready=0 for 20 cycles after out_valid while toggling bit_in -> result and out_valid unchanged; then out_ready=1 with start=1 -> next cycle busy=1, out_valid=0, counts restart from 0.
- Assert rst low at sample 9 of 16 -> busy=0, out_valid=0, result=0 immediately; new start after release yields correct full-window count.
- clear=1 in HOLD with out_ready=1 and start=1 same cycle -> IDLE, no restart, result=0.
- Random bitstream p=0.25, WIDTH=8 -> result equals reference ones count over the 256 valid samples exactly.

Source files
------------

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WIDTH valid samples and hands the count out
// with a valid/ready handshake. Define SC_DECODER_BIPOLAR_EN for signed bipolar (2*ones - 2^WIDTH).
module sc_bitstream_decoder #(
  parameter int unsigned WIDTH = 8,
`ifdef SC_DECODER_BIPOLAR_EN
  localparam int unsigned ResultWidth = WIDTH + 2
`else
  localparam int unsigned ResultWidth = WIDTH + 1
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ResultWidth-1:0] result
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  // Sample index of the final sample in a window (2^WIDTH - 1).
  localparam logic [WIDTH:0] LastSample = {1'b0, {WIDTH{1'b1}}};

  state_e                 state_q;
  logic [WIDTH:0]         ones_q;
  logic [WIDTH:0]         samples_q;
  logic [WIDTH:0]         ones_inc;
  logic [ResultWidth-1:0] result_calc;

  always_comb begin
    ones_inc = ones_q + {{WIDTH{1'b0}}, bit_in};
`ifdef SC_DECODER_BIPOLAR_EN
    // 2*ones - 2^WIDTH; the concat is exactly ResultWidth bits so the doubling cannot overflow.
    result_calc = {ones_inc, 1'b0} - (ResultWidth'(1) << WIDTH);
`else
    result_calc = ones_inc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ones_q    <= '0;
      samples_q <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (clear) begin
      state_q   <= StIdle;
      ones_q    <= '0;
      samples_q <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StAccum;
            ones_q    <= '0;
            samples_q <= '0;
            busy      <= 1'b1;
          end
        end
        StAccum: begin
          if (bit_valid) begin
            ones_q    <= ones_inc;
            samples_q <= samples_q + 1'b1;
            if (samples_q == LastSample) begin
              state_q   <= StHold;
              result    <= result_calc;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state_q   <= StAccum;
              ones_q    <= '0;
              samples_q <= '0;
              busy      <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
